// File: rtl/icache_assoc_if.sv
// Fetch-side and refill-side signal bundle for icache_assoc.
// slave = cache view, master = fetch/memory environment view.
interface icache_assoc_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  fetch_req, fetch_addr, flush,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output fetch_ready, fetch_valid, fetch_data,
    output mem_req, mem_addr, hit_count, miss_count
  );

  modport master (
    output fetch_req, fetch_addr, flush,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  fetch_ready, fetch_valid, fetch_data,
    input  mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative i-cache with self-driven line refill.
// ICACHE_PERF_CNT_EN enables the saturating hit/miss counters.
module icache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input logic         CLK,
  input logic         RESET,
  icache_assoc_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LSB_T = IDX_W + OFF_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [31:0]      r_data [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0] r_tag  [WAYS][SETS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAY_W-1:0] r_rr    [SETS];

  logic [31:0]      r_addr;
  logic [31:0]      r_mem_addr;
  logic [WAY_W-1:0] r_vict;
  logic [OFF_W-1:0] r_beat;
  logic [31:0]      r_word;
  logic             r_flush_pend;
  logic             r_fetch_valid;
  logic [31:0]      r_fetch_data;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [OFF_W-1:0] w_r_off;
  logic [IDX_W-1:0] w_r_idx;
  logic [TAG_W-1:0] w_r_tag;
  logic             w_hit;
  logic [31:0]      w_hit_data;
  logic [WAY_W-1:0] w_victim;
  logic             w_use_rr;
  logic [WAY_W-1:0] w_rr_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_ready;
  logic             w_mem_req;

  assign w_off   = bus.fetch_addr[OFF_W+1:2];
  assign w_idx   = bus.fetch_addr[LSB_T-1:OFF_W+2];
  assign w_tag   = bus.fetch_addr[31:LSB_T];
  assign w_r_off = r_addr[OFF_W+1:2];
  assign w_r_idx = r_addr[LSB_T-1:OFF_W+2];
  assign w_r_tag = r_addr[31:LSB_T];

  assign w_accept = bus.fetch_req && w_ready;
  assign w_last   = (r_beat == OFF_W'(LINE_WORDS - 1));

  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w][w_idx][w_off];
      end
    end
  end

  // lowest invalid way wins; round-robin only when the set is full
  always_comb begin
    w_victim = r_rr[w_idx];
    w_use_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_victim = WAY_W'(w);
        w_use_rr = 1'b0;
      end
    end
  end

  assign w_rr_nxt = (r_rr[w_idx] == WAY_W'(WAYS - 1)) ?
                    '0 : r_rr[w_idx] + 1'b1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_ready   = 1'b0;
    w_mem_req = 1'b0;
    unique case (1'b1)
      r_state == S_IDLE: begin
        w_ready = !bus.flush && !r_flush_pend;
        if (bus.fetch_req && w_ready && !w_hit)
          w_nxt = S_REQ;
      end
      r_state == S_REQ: begin
        w_mem_req = 1'b1;
        if (bus.mem_gnt) w_nxt = S_FILL;
      end
      r_state == S_FILL: begin
        if (bus.mem_rvalid && w_last)
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_addr        <= '0;
      r_mem_addr    <= '0;
      r_vict        <= '0;
      r_beat        <= '0;
      r_word        <= '0;
      r_flush_pend  <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_fetch_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.flush || r_flush_pend) begin
          r_flush_pend <= 1'b0;
          for (int s = 0; s < SETS; s++)
            r_valid[s] <= '0;
        end else if (w_accept && w_hit) begin
          r_fetch_valid <= 1'b1;
          r_fetch_data  <= w_hit_data;
        end else if (w_accept) begin
          r_addr     <= bus.fetch_addr;
          r_mem_addr <= {bus.fetch_addr[31:OFF_W+2],
                         {(OFF_W + 2){1'b0}}};
          r_vict     <= w_victim;
          r_beat     <= '0;
          if (w_use_rr) r_rr[w_idx] <= w_rr_nxt;
        end
      end else begin
        if (bus.flush) r_flush_pend <= 1'b1;
        if (r_state == S_FILL && bus.mem_rvalid) begin
          r_beat <= r_beat + 1'b1;
          if (r_beat == w_r_off) r_word <= bus.mem_rdata;
          if (w_last) begin
            r_valid[w_r_idx][r_vict] <= 1'b1;
            r_fetch_valid <= 1'b1;
            r_fetch_data  <= (r_beat == w_r_off) ?
                             bus.mem_rdata : r_word;
          end
        end
      end
    end
  end

  // data and tags carry no reset; valid bits guard them
  always_ff @(posedge CLK) begin
    if (r_state == S_FILL && bus.mem_rvalid) begin
      r_data[r_vict][w_r_idx][r_beat] <= bus.mem_rdata;
      if (w_last) r_tag[r_vict][w_r_idx] <= w_r_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit && r_hit_cnt != 32'hFFFF_FFFF)
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (!w_hit && r_miss_cnt != 32'hFFFF_FFFF)
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

  assign bus.fetch_ready = w_ready;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_data  = r_fetch_data;
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = r_mem_addr;
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters.
// Expected words are derived from per-line beat seeds.
module tb_icache_assoc;
  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  icache_assoc_if bus();

  icache_assoc #(
    .WAYS(2), .SETS(64), .LINE_WORDS(4)
  ) dut (
    .CLK(clk),
    .RESET(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // full miss transaction; reports mem_req one cycle after accept
  task automatic refill(
    input  logic [31:0] addr,
    input  logic [31:0] seed,
    output logic        o_req,
    output logic        o_valid,
    output logic [31:0] o_data
  );
    bus.fetch_addr = addr;
    bus.fetch_req  = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    o_req = bus.mem_req;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = seed + 32'(b);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    o_valid = bus.fetch_valid;
    o_data  = bus.fetch_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.fetch_ready !== 1'b1) begin
      errs++; $display("FAIL rst_ready got %b want 1", bus.fetch_ready);
    end
    vecs++;
    if (bus.fetch_valid !== 1'b0 || bus.fetch_data !== 32'h0) begin
      errs++; $display("FAIL rst_fetch got %b/%h want 0/0",
                       bus.fetch_valid, bus.fetch_data);
    end
    vecs++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      errs++; $display("FAIL rst_mem got %b/%h want 0/0",
                       bus.mem_req, bus.mem_addr);
    end
    vecs++;
    if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
      errs++; $display("FAIL rst_cnt got %h/%h want 0/0",
                       bus.hit_count, bus.miss_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss();
    logic [31:0] exp_h;
    logic [31:0] exp_m;
    bus.fetch_addr = 32'h0000_1008;
    bus.fetch_req  = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    vecs++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_1000) begin
      errs++; $display("FAIL cold_req got %b/%h want 1/00001000",
                       bus.mem_req, bus.mem_addr);
    end
    vecs++;
    if (bus.fetch_ready !== 1'b0) begin
      errs++; $display("FAIL cold_rdy_req got %b want 0", bus.fetch_ready);
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    vecs++;
    if (bus.mem_req !== 1'b0) begin
      errs++; $display("FAIL cold_req_drop got %b want 0", bus.mem_req);
    end
    for (int b = 0; b < 4; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA0A0_0000 + 32'(b);
      tick();
      if (b < 3) begin
        vecs++;
        if (bus.fetch_valid !== 1'b0) begin
          errs++; $display("FAIL cold_early beat %0d got 1 want 0", b);
        end
      end
    end
    bus.mem_rvalid = 1'b0;
    vecs++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'hA0A0_0002) begin
      errs++; $display("FAIL cold_resp got %b/%h want 1/a0a00002",
                       bus.fetch_valid, bus.fetch_data);
    end
    vecs++;
    if (bus.fetch_ready !== 1'b1) begin
      errs++; $display("FAIL cold_rdy_back got %b want 1", bus.fetch_ready);
    end
    bus.fetch_addr = 32'h0000_100C;
    bus.fetch_req  = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    vecs++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'hA0A0_0003) begin
      errs++; $display("FAIL cold_hit got %b/%h want 1/a0a00003",
                       bus.fetch_valid, bus.fetch_data);
    end
    vecs++;
    if (bus.mem_req !== 1'b0) begin
      errs++; $display("FAIL cold_hit_req got %b want 0", bus.mem_req);
    end
`ifdef ICACHE_PERF_CNT_EN
    exp_h = 32'd1;
    exp_m = 32'd1;
`else
    exp_h = 32'd0;
    exp_m = 32'd0;
`endif
    vecs++;
    if (bus.hit_count !== exp_h || bus.miss_count !== exp_m) begin
      errs++; $display("FAIL counters got %h/%h want %h/%h",
                       bus.hit_count, bus.miss_count, exp_h, exp_m);
    end
    tick();
    vecs++;
    if (bus.fetch_valid !== 1'b0) begin
      errs++; $display("FAIL hit_pulse got 1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0000_1000;
    tick();
    bus.fetch_addr = 32'h0000_1004;
    vecs++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'hA0A0_0000) begin
      errs++; $display("FAIL b2b_0 got %b/%h want 1/a0a00000",
                       bus.fetch_valid, bus.fetch_data);
    end
    tick();
    bus.fetch_req = 1'b0;
    vecs++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'hA0A0_0001) begin
      errs++; $display("FAIL b2b_1 got %b/%h want 1/a0a00001",
                       bus.fetch_valid, bus.fetch_data);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic        rq;
    logic        vl;
    logic [31:0] dt;
    pulse_reset();
    refill(32'h0000_1000, 32'h1100_0000, rq, vl, dt);
    vecs++;
    if (rq !== 1'b1 || vl !== 1'b1 || dt !== 32'h1100_0000) begin
      errs++; $display("FAIL cf_1000 got %b/%b/%h want 1/1/11000000",
                       rq, vl, dt);
    end
    refill(32'h0000_2000, 32'h2200_0000, rq, vl, dt);
    vecs++;
    if (rq !== 1'b1 || vl !== 1'b1 || dt !== 32'h2200_0000) begin
      errs++; $display("FAIL cf_2000 got %b/%b/%h want 1/1/22000000",
                       rq, vl, dt);
    end
    refill(32'h0000_3000, 32'h3300_0000, rq, vl, dt);
    vecs++;
    if (rq !== 1'b1 || dt !== 32'h3300_0000) begin
      errs++; $display("FAIL cf_3000 got %b/%h want 1/33000000", rq, dt);
    end
    bus.fetch_addr = 32'h0000_2004;
    bus.fetch_req  = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    vecs++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h2200_0001 ||
        bus.mem_req !== 1'b0) begin
      errs++; $display("FAIL cf_hit2000 got %b/%h/%b want 1/22000001/0",
                       bus.fetch_valid, bus.fetch_data, bus.mem_req);
    end
    refill(32'h0000_1000, 32'h4400_0000, rq, vl, dt);
    vecs++;
    if (rq !== 1'b1 || dt !== 32'h4400_0000) begin
      errs++; $display("FAIL cf_re1000 got %b/%h want 1/44000000", rq, dt);
    end
    refill(32'h0000_2008, 32'h5500_0000, rq, vl, dt);
    vecs++;
    if (rq !== 1'b1 || dt !== 32'h5500_0002) begin
      errs++; $display("FAIL cf_re2000 got %b/%h want 1/55000002", rq, dt);
    end
  endtask

  task automatic test_stall_gaps();
    bus.fetch_addr = 32'h0000_4018;
    bus.fetch_req  = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_4010 ||
          bus.fetch_ready !== 1'b0) begin
        errs++; $display("FAIL stall_%0d got %b/%h/%b want 1/00004010/0",
                         i, bus.mem_req, bus.mem_addr, bus.fetch_ready);
      end
      tick();
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat (2) begin
        bus.mem_rvalid = 1'b0;
        tick();
        vecs++;
        if (bus.fetch_valid !== 1'b0) begin
          errs++; $display("FAIL gap_valid beat %0d got 1 want 0", b);
        end
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h6600_0000 + 32'(b);
      tick();
      bus.mem_rvalid = 1'b0;
    end
    vecs++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h6600_0002) begin
      errs++; $display("FAIL gap_resp got %b/%h want 1/66000002",
                       bus.fetch_valid, bus.fetch_data);
    end
  endtask

  task automatic test_flush();
    logic        rq;
    logic        vl;
    logic [31:0] dt;
    pulse_reset();
    bus.fetch_addr = 32'h0000_1004;
    bus.fetch_req  = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    bus.mem_gnt   = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h7700_0000 + 32'(b);
      bus.flush      = (b == 1);
      tick();
    end
    bus.flush      = 1'b0;
    bus.mem_rvalid = 1'b0;
    vecs++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h7700_0001) begin
      errs++; $display("FAIL fl_resp got %b/%h want 1/77000001",
                       bus.fetch_valid, bus.fetch_data);
    end
    vecs++;
    if (bus.fetch_ready !== 1'b0) begin
      errs++; $display("FAIL fl_ready_low got %b want 0", bus.fetch_ready);
    end
    tick();
    vecs++;
    if (bus.fetch_ready !== 1'b1) begin
      errs++; $display("FAIL fl_ready_back got %b want 1", bus.fetch_ready);
    end
    refill(32'h0000_1000, 32'h8800_0000, rq, vl, dt);
    vecs++;
    if (rq !== 1'b1 || dt !== 32'h8800_0000) begin
      errs++; $display("FAIL fl_remiss got %b/%h want 1/88000000", rq, dt);
    end
    bus.flush      = 1'b1;
    bus.fetch_addr = 32'h0000_1000;
    bus.fetch_req  = 1'b1;
    #1;
    vecs++;
    if (bus.fetch_ready !== 1'b0) begin
      errs++; $display("FAIL fl_idle_rdy got %b want 0", bus.fetch_ready);
    end
    tick();
    bus.flush     = 1'b0;
    bus.fetch_req = 1'b0;
    vecs++;
    if (bus.fetch_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errs++; $display("FAIL fl_idle_acc got %b/%b want 0/0",
                       bus.fetch_valid, bus.mem_req);
    end
    refill(32'h0000_1000, 32'h9900_0000, rq, vl, dt);
    vecs++;
    if (rq !== 1'b1 || dt !== 32'h9900_0000) begin
      errs++; $display("FAIL fl_idle_clr got %b/%h want 1/99000000", rq, dt);
    end
  endtask

  task automatic test_reset_fill();
    logic        rq;
    logic        vl;
    logic [31:0] dt;
    bus.fetch_addr = 32'h0000_5000;
    bus.fetch_req  = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    bus.mem_gnt   = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBB00_0000;
    tick();
    tick();
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.mem_req !== 1'b0 || bus.fetch_ready !== 1'b1) begin
      errs++; $display("FAIL rf_rst got %b/%b want 0/1",
                       bus.mem_req, bus.fetch_ready);
    end
    tick();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (bus.fetch_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
        errs++; $display("FAIL rf_stray_%0d got %b/%b want 0/0",
                         i, bus.fetch_valid, bus.mem_req);
      end
    end
    bus.mem_rvalid = 1'b0;
    tick();
    refill(32'h0000_1000, 32'hCC00_0000, rq, vl, dt);
    vecs++;
    if (rq !== 1'b1 || vl !== 1'b1 || dt !== 32'hCC00_0000) begin
      errs++; $display("FAIL rf_prior got %b/%b/%h want 1/1/cc000000",
                       rq, vl, dt);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_stall_gaps();
    test_flush();
    test_reset_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
